mer_calc: RTL and testbench
===========================

# mer_calc

Converts the per-window averages produced by the MER measurement chain into a modulation error ratio in dB. At each LFSR window boundary (`cycle` pulse) it captures the averaged reference-level power `map_out_pwr` and the averaged error power `err_square`. It then runs a sequential restoring divider, a Mitchell log2 approximation and a constant scale, and presents `mer_db = 10·log10(map_out_pwr / err_square)` with a one-cycle valid strobe. It sits directly downstream of the average-magnitude and average-error-squared stages and feeds SignalTap and ISSP probes.

## Interface
- `DIV_ITERS`, 25, divider iterations; equals numerator width (17 magnitude bits + 8 fraction bits).
- `SCALE_K`, 771, 10·log10(2) in UQ2.8 (771/256 = 3.0117).
- CLOCK_50  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- sym_clk_en  in  1  symbol-rate enable.
- cycle  in  1  LFSR window-end flag; sampled only when sym_clk_en=1.
- map_out_pwr  in  18  signed 1s17, average reference power.
- err_square  in  18  signed 1s17, average squared error.
- mer_db  out  16  signed s7.8 dB; holds last result.
- mer_valid  out  1  one-cycle pulse when mer_db updates.
- busy  out  1  high from capture until the mer_valid cycle, inclusive of neither IDLE cycle.
- mer_sat  out  1  sticky per-result flag: result saturated (den=0 or num=0).
- overrun_cnt  out  8  dropped-capture count (see Configuration).

## Operation
- Capture condition: `cycle & sym_clk_en` while the FSM is in IDLE.
- On capture:
  - num = max(map_out_pwr, 0)[16:0].
  - den = max(err_square, 0)[16:0]; negative inputs clamp to 0.
- FSM states:
  - IDLE: on capture, go to DIV.
  - DIV: 25 cycles, then LOG.
  - LOG: 1 cycle, then SCALE.
  - SCALE: 1 cycle, then IDLE.
- Special-case capture outcomes:
  - den=0: skip DIV/LOG; mer_db=0x7FFF, mer_sat=1.
  - num=0 with den≠0: mer_db=0x8000, mer_sat=1.
  - In both special cases mer_valid is still issued at the normal latency.
- DIV: restoring shift-subtract of {num, 8'b0} by den, one quotient bit per cycle, MSB first. Q is a 25-bit unsigned UQ17.8 value = floor(num·256/den).
- LOG: k = leading-one index of Q (0..24). log2 = (k − 8) in integer bits, plus frac. frac = the 8 bits immediately below the leading one, zero-padded on the right when k<8. Result L is signed Q6.8 (range −8.0 … +16.996).
- SCALE: mer_db = (L·SCALE_K) >>> 8, arithmetic shift, truncating. The s7.8 range covers −24.1 … +51.2 dB, so no further saturation is needed.
- mer_sat is rewritten with every mer_valid (0 for normal results).

## Timing
- Capture edge = E0.
- DIV runs on E1..E25, LOG on E26, SCALE on E27.
- mer_db, mer_sat and mer_valid update on E27; mer_valid is high for exactly the one cycle following E27.
- busy = 1 after E0 through the cycle following E27; 0 in IDLE.
- A capture condition arriving while busy=1 (including the mer_valid cycle) is dropped; no queueing.
- Reset values: mer_db=0, mer_valid=0, busy=0, mer_sat=0, overrun_cnt=0, FSM=IDLE.
- Reset mid-operation aborts immediately: no mer_valid is issued and mer_db returns to 0.
- Reset takes priority over a simultaneous capture.
- Input changes after E0 do not affect the current result.

## Configuration
- `MER_CALC_OVERRUN_CNT_EN` defined:
  - overrun_cnt increments, saturating at 255, on each capture condition seen while busy=1.
  - overrun_cnt is cleared only by reset.
- Not defined: overrun_cnt is tied to 0 and no counter logic is built.

## Test plan
- map_out_pwr=256, err_square=256, cycle=1 with sym_clk_en=1 -> Q=256, mer_valid after E27 with mer_db=0x0000, mer_sat=0.
- map_out_pwr=1024, err_square=1 -> Q=2^18, L=0x0A00, mer_db=0x1E1E (30.117 dB).
- err_square=0, map_out_pwr=9268 -> mer_db=0x7FFF, mer_sat=1, mer_valid at normal latency; then map_out_pwr=0, err_square=5 -> mer_db=0x8000, mer_sat=1.
- map_out_pwr=−100 (negative), err_square=10 -> clamped to num=0, mer_db=0x8000, mer_sat=1.
- Second capture at E10 of a running computation -> ignored, one mer_valid only; overrun_cnt=1 with the macro, 0 without.
- Reset asserted at E12 of DIV -> busy=0 the next cycle, mer_db=0, no mer_valid; a fresh capture afterwards completes normally at E0+27.

Source files
------------

// File: rtl/mer_calc_if.sv
// mer_calc_if: bundles the MER calculator's measurement inputs, result
// outputs and FSM debug state.
//
// Signalling: there is no backpressure. The producer asserts cycle together
// with sym_clk_en for one clock to request a capture; the request is taken
// only when the block is idle and busy is low, otherwise it is dropped.
// mer_valid is a one-cycle strobe and mer_db/mer_sat are valid in that cycle
// and hold afterwards.
interface mer_calc_if;
    logic               sym_clk_en;
    logic               cycle;
    logic signed [17:0] map_out_pwr;
    logic signed [17:0] err_square;
    logic signed [15:0] mer_db;
    logic               mer_valid;
    logic               busy;
    logic               mer_sat;
    logic [7:0]         overrun_cnt;
    logic [1:0]         state_dbg;

    modport master (
        output sym_clk_en, cycle, map_out_pwr, err_square,
        input  mer_db, mer_valid, busy, mer_sat, overrun_cnt, state_dbg
    );

    modport slave (
        input  sym_clk_en, cycle, map_out_pwr, err_square,
        output mer_db, mer_valid, busy, mer_sat, overrun_cnt, state_dbg
    );
endinterface

// File: rtl/mer_calc.sv
// mer_calc: turns averaged reference power and averaged error power into
// MER in dB (s7.8) using a restoring divider, a Mitchell log2 and a constant
// scale of 10*log10(2). Latency is 27 clocks from capture to result.
// Optional feature: define MER_CALC_OVERRUN_CNT_EN to count captures that
// arrive while a computation is in flight; otherwise overrun_cnt is 0.
module mer_calc #(
    parameter int DIV_ITERS = 25,
    parameter int SCALE_K   = 771
) (
    input logic   CLOCK_50,
    input logic   reset,
    mer_calc_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIV   = 2'd1,
        LOG   = 2'd2,
        SCALE = 2'd3
    } state_t;

    state_t             state;
    logic [4:0]         iter;
    logic [24:0]        quo;        // dividend in, quotient out, shifted MSB first
    logic [16:0]        rem;
    logic [16:0]        den;
    logic               den_zero;
    logic               num_zero;
    logic signed [13:0] log_l;      // Q6.8 log2 of the quotient
    logic signed [15:0] db_r;
    logic               valid_r;
    logic               busy_r;
    logic               sat_r;

    logic               capture_req;
    logic               capture;
    logic [17:0]        trial;
    logic               fits;
    logic [16:0]        diff;
    logic [4:0]         lead;
    logic [4:0]         norm_shift;
    logic [7:0]         frac;
    logic [5:0]         int_part;
    logic signed [13:0] log_next;
    logic signed [23:0] l_ext;
    logic signed [23:0] k_ext;
    logic signed [23:0] prod;

    assign capture_req = bus.cycle & bus.sym_clk_en;
    // busy stays high through the mer_valid cycle, which blocks capture there
    assign capture     = capture_req && (state == IDLE) && !busy_r;

    // One restoring-division step: bring down the next dividend bit and try
    // to subtract the divisor. When it fits the difference is below den, so
    // 17-bit modular subtraction is exact.
    assign trial = {rem, quo[24]};
    assign fits  = (trial >= {1'b0, den});
    assign diff  = trial[16:0] - den;

    // Leading-one index of the quotient. A zero quotient (num much smaller
    // than den) falls through as index 0, giving the minimum log of -8.0.
    always_comb begin
        lead = 5'd0;
        for (int i = 0; i < 25; i++) begin
            if (quo[i]) lead = 5'(i);
        end
    end

    // Mitchell log2: integer part k-8, fraction = 8 bits below the leading one
    assign norm_shift = 5'd24 - lead;
    assign frac       = 8'((quo << norm_shift) >> 16);
    assign int_part   = {1'b0, lead} - 6'd8;
    assign log_next   = {int_part, frac};

    // Scale Q6.8 log2 by 10*log10(2) in UQ2.8; product stays well inside 24 bits
    assign l_ext = {{10{log_l[13]}}, log_l};
    assign k_ext = 24'(SCALE_K);
    assign prod  = l_ext * k_ext;

    // Main FSM: capture, divide, take the log, scale and publish
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state    <= IDLE;
            iter     <= 5'd0;
            quo      <= 25'd0;
            rem      <= 17'd0;
            den      <= 17'd0;
            den_zero <= 1'b0;
            num_zero <= 1'b0;
            log_l    <= 14'sd0;
            db_r     <= 16'sd0;
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
            sat_r    <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (capture) begin
                        quo      <= {(bus.map_out_pwr[17] ? 17'd0 : bus.map_out_pwr[16:0]), 8'd0};
                        den      <= bus.err_square[17] ? 17'd0 : bus.err_square[16:0];
                        num_zero <= bus.map_out_pwr[17] || (bus.map_out_pwr[16:0] == 17'd0);
                        den_zero <= bus.err_square[17] || (bus.err_square[16:0] == 17'd0);
                        rem      <= 17'd0;
                        iter     <= 5'd0;
                        busy_r   <= 1'b1;
                        state    <= DIV;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                DIV: begin
                    quo <= {quo[23:0], fits};
                    rem <= fits ? diff : trial[16:0];
                    if (iter == 5'(DIV_ITERS - 1)) begin
                        state <= LOG;
                    end else begin
                        iter <= iter + 5'd1;
                    end
                end
                LOG: begin
                    log_l <= log_next;
                    state <= SCALE;
                end
                SCALE: begin
                    valid_r <= 1'b1;
                    if (den_zero) begin
                        db_r  <= 16'sh7FFF;
                        sat_r <= 1'b1;
                    end else if (num_zero) begin
                        db_r  <= 16'sh8000;
                        sat_r <= 1'b1;
                    end else begin
                        db_r  <= prod[23:8];
                        sat_r <= 1'b0;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MER_CALC_OVERRUN_CNT_EN
    logic [7:0] overrun_r;

    // Count capture requests dropped while busy, saturating at 255
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            overrun_r <= 8'd0;
        end else if (capture_req && busy_r && (overrun_r != 8'hFF)) begin
            overrun_r <= overrun_r + 8'd1;
        end
    end

    assign bus.overrun_cnt = overrun_r;
`else
    assign bus.overrun_cnt = 8'd0;
`endif

    assign bus.mer_db    = db_r;
    assign bus.mer_valid = valid_r;
    assign bus.busy      = busy_r;
    assign bus.mer_sat   = sat_r;
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_mer_calc.sv
// tb_mer_calc: directed and randomized checks of mer_calc against a
// behavioural model of 10*log10(num/den) via Mitchell log2.
module tb_mer_calc;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;

    mer_calc_if bus();

    mer_calc dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bus.slave)
    );

    // Clock / reset
    always #10 CLOCK_50 = ~CLOCK_50;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q[$];
    logic [0:0]  exp_sat_q[$];

`ifdef MER_CALC_OVERRUN_CNT_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    // Reference model: clamp, exact floor division, Mitchell log, scale
    function automatic void model_mer(input int pwr, input int err,
                                      output logic [15:0] db, output logic sat);
        longint num, den, q, scaled;
        int k, fr, l;
        num = (pwr < 0) ? 0 : pwr;
        den = (err < 0) ? 0 : err;
        if (den == 0) begin
            db = 16'h7FFF; sat = 1'b1;
        end else if (num == 0) begin
            db = 16'h8000; sat = 1'b1;
        end else begin
            q = (num * 256) / den;
            k = 0;
            for (int i = 0; i < 25; i++) if (q >= (longint'(1) << i)) k = i;
            scaled = (q * 256) >> k;
            fr = int'(scaled % 256);
            l  = (k - 8) * 256 + fr;
            db = 16'((l * 771) >>> 8);
            sat = 1'b0;
        end
    endfunction

    // Driver tasks
    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic drive_capture(input int pwr, input int err);
        bus.map_out_pwr = 18'(pwr);
        bus.err_square  = 18'(err);
        bus.cycle       = 1'b1;
        bus.sym_clk_en  = 1'b1;
        step();
        // scramble inputs after capture; they must not affect the result
        bus.cycle       = 1'b0;
        bus.sym_clk_en  = 1'($urandom_range(0, 1));
        bus.map_out_pwr = 18'($urandom);
        bus.err_square  = 18'($urandom);
    endtask

    task automatic wait_valid(output int lat, output logic [15:0] db,
                              output logic sat, output logic busy_ok);
        lat = 0; db = 16'h0; sat = 1'b0; busy_ok = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            step();
            if (!bus.busy) busy_ok = 1'b0;
            if (bus.mer_valid) begin
                lat = n; db = bus.mer_db; sat = bus.mer_sat;
                return;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) step();
        reset = 1'b0;
        step();
        checks++; if (bus.mer_db !== 16'h0)      begin errors++; $display("FAIL reset_db got=%h exp=0000", bus.mer_db); end
        checks++; if (bus.mer_valid !== 1'b0)    begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.mer_valid); end
        checks++; if (bus.busy !== 1'b0)         begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.mer_sat !== 1'b0)      begin errors++; $display("FAIL reset_sat got=%b exp=0", bus.mer_sat); end
        checks++; if (bus.overrun_cnt !== 8'd0)  begin errors++; $display("FAIL reset_ovr got=%0d exp=0", bus.overrun_cnt); end
        checks++; if (bus.state_dbg !== 2'd0)    begin errors++; $display("FAIL reset_state got=%0d exp=0", bus.state_dbg); end
    endtask

    task automatic test_enable_gate();
        bus.cycle = 1'b1; bus.sym_clk_en = 1'b0;
        bus.map_out_pwr = 18'd256; bus.err_square = 18'd256;
        step();
        bus.cycle = 1'b0;
        checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL gate_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.state_dbg !== 2'd0) begin errors++; $display("FAIL gate_state got=%0d exp=0", bus.state_dbg); end
    endtask

    task automatic test_directed();
        int pwr_t[5] = '{256, 1024, 9268, 0, -100};
        int err_t[5] = '{256, 1, 0, 5, 10};
        logic [15:0] db_t[5] = '{16'h0000, 16'h1E1E, 16'h7FFF, 16'h8000, 16'h8000};
        logic sat_t[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        int lat; logic [15:0] db; logic sat, busy_ok;
        for (int i = 0; i < 5; i++) begin
            drive_capture(pwr_t[i], err_t[i]);
            checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL dir%0d_busy_e0 got=%b exp=1", i, bus.busy); end
            wait_valid(lat, db, sat, busy_ok);
            checks++; if (lat !== 27)    begin errors++; $display("FAIL dir%0d_latency got=%0d exp=27", i, lat); end
            checks++; if (db !== db_t[i]) begin errors++; $display("FAIL dir%0d_db got=%h exp=%h", i, db, db_t[i]); end
            checks++; if (sat !== sat_t[i]) begin errors++; $display("FAIL dir%0d_sat got=%b exp=%b", i, sat, sat_t[i]); end
            checks++; if (busy_ok !== 1'b1) begin errors++; $display("FAIL dir%0d_busy_hold got=%b exp=1", i, busy_ok); end
            step();
            checks++; if (bus.mer_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_valid_pulse got=%b exp=0", i, bus.mer_valid); end
            checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL dir%0d_busy_end got=%b exp=0", i, bus.busy); end
            checks++; if (bus.mer_db !== db_t[i]) begin errors++; $display("FAIL dir%0d_db_hold got=%h exp=%h", i, bus.mer_db, db_t[i]); end
        end
    endtask

    task automatic test_random();
        int pwr, err, r, lat; logic [15:0] db, e_db; logic sat, busy_ok, e_sat;
        for (int i = 0; i < 24; i++) begin
            r = $urandom_range(0, 9);
            pwr = (r == 0) ? -int'($urandom_range(1, 131072)) : int'($urandom_range(0, 131071));
            r = $urandom_range(0, 9);
            if (r == 0)      err = 0;
            else if (r == 1) err = -int'($urandom_range(1, 131072));
            else if (r < 6)  err = int'($urandom_range(1, 512));
            else             err = int'($urandom_range(1, 131071));
            model_mer(pwr, err, e_db, e_sat);
            exp_q.push_back(e_db);
            exp_sat_q.push_back(e_sat);
            drive_capture(pwr, err);
            wait_valid(lat, db, sat, busy_ok);
            e_db = exp_q.pop_front();
            e_sat = exp_sat_q.pop_front();
            checks++; if (lat !== 27) begin errors++; $display("FAIL rnd%0d_latency got=%0d exp=27", i, lat); end
            checks++; if (db !== e_db) begin errors++; $display("FAIL rnd%0d_db pwr=%0d err=%0d got=%h exp=%h", i, pwr, err, db, e_db); end
            checks++; if (sat !== e_sat) begin errors++; $display("FAIL rnd%0d_sat got=%b exp=%b", i, sat, e_sat); end
            step();
        end
    endtask

    task automatic test_overrun();
        int valids, lat; logic [15:0] e_db, got_db; logic e_sat;
        valids = 0; lat = 0; got_db = 16'h0;
        model_mer(5000, 7, e_db, e_sat);
        drive_capture(5000, 7);
        for (int n = 1; n <= 45; n++) begin
            // requests at E10 (mid-divide) and E28 (during the mer_valid cycle)
            if (n == 10 || n == 28) begin
                bus.cycle = 1'b1; bus.sym_clk_en = 1'b1;
                bus.map_out_pwr = 18'd1; bus.err_square = 18'd1;
            end
            step();
            bus.cycle = 1'b0;
            if (bus.mer_valid) begin
                valids++;
                if (lat == 0) begin lat = n; got_db = bus.mer_db; end
            end
        end
        checks++; if (valids !== 1)   begin errors++; $display("FAIL ovr_valid_count got=%0d exp=1", valids); end
        checks++; if (lat !== 27)     begin errors++; $display("FAIL ovr_latency got=%0d exp=27", lat); end
        checks++; if (got_db !== e_db) begin errors++; $display("FAIL ovr_db got=%h exp=%h", got_db, e_db); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ovr_busy_after got=%b exp=0", bus.busy); end
        checks++; if (bus.overrun_cnt !== (OVR_EN ? 8'd2 : 8'd0))
            begin errors++; $display("FAIL ovr_count got=%0d exp=%0d", bus.overrun_cnt, OVR_EN ? 2 : 0); end
    endtask

    task automatic test_reset_mid();
        int valids, lat; logic [15:0] db; logic sat, busy_ok;
        valids = 0;
        drive_capture(30000, 3);
        repeat (11) step();
        // reset at E12 with a simultaneous capture request: reset wins
        reset = 1'b1;
        bus.cycle = 1'b1; bus.sym_clk_en = 1'b1;
        bus.map_out_pwr = 18'd256; bus.err_square = 18'd256;
        step();
        bus.cycle = 1'b0;
        reset = 1'b0;
        checks++; if (bus.busy !== 1'b0)        begin errors++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.mer_db !== 16'h0)     begin errors++; $display("FAIL rstmid_db got=%h exp=0000", bus.mer_db); end
        checks++; if (bus.state_dbg !== 2'd0)   begin errors++; $display("FAIL rstmid_state got=%0d exp=0", bus.state_dbg); end
        checks++; if (bus.overrun_cnt !== 8'd0) begin errors++; $display("FAIL rstmid_ovr got=%0d exp=0", bus.overrun_cnt); end
        for (int n = 0; n < 40; n++) begin
            step();
            if (bus.mer_valid || bus.busy) valids++;
        end
        checks++; if (valids !== 0) begin errors++; $display("FAIL rstmid_no_valid got=%0d exp=0", valids); end
        drive_capture(1024, 1);
        wait_valid(lat, db, sat, busy_ok);
        checks++; if (lat !== 27)      begin errors++; $display("FAIL rstmid_fresh_latency got=%0d exp=27", lat); end
        checks++; if (db !== 16'h1E1E) begin errors++; $display("FAIL rstmid_fresh_db got=%h exp=1e1e", db); end
        checks++; if (sat !== 1'b0)    begin errors++; $display("FAIL rstmid_fresh_sat got=%b exp=0", sat); end
        step();
    endtask

    // Watchdog bounds the whole run
    initial begin
        #2000000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cycle       = 1'b0;
        bus.sym_clk_en  = 1'b0;
        bus.map_out_pwr = 18'd0;
        bus.err_square  = 18'd0;
        test_reset();
        test_enable_gate();
        test_directed();
        test_random();
        test_overrun();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
